// File: rtl/msrv32_pc_redirect_ctrl.sv
// Program counter owner and next-fetch-address selector for the msrv32 core.
// Arbitrates trap / mret / branch redirects and generates a registered pipeline flush.
module msrv32_pc_redirect_ctrl #(
  parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000,
  parameter int          FLUSH_CYCLES = 1,
  parameter int          CNT_W        = 16
) (
  input  logic             ms_riscv32_mp_clk_in,
  input  logic             ms_riscv32_mp_rst_in,
  input  logic             branch_taken_in,
  input  logic [4:0]       opcode_6_to_2_in,
  input  logic [31:0]      rs1_in,
  input  logic [31:0]      imm_in,
  input  logic             trap_taken_in,
  input  logic [31:0]      trap_address_in,
  input  logic             mret_in,
  input  logic [31:0]      epc_in,
  input  logic             stall_in,
  output logic [31:0]      pc_out,
  output logic [31:0]      iaddr_out,
  output logic [31:0]      pc_plus_4_out,
  output logic             misaligned_instr_out,
  output logic             flush_out,
  output logic [CNT_W-1:0] redirect_count_out
);

  localparam logic [4:0] OPC_JALR     = 5'b11001;
  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_FLUSH
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [2:0]       flush_cnt;
  logic [2:0]       flush_cnt_next;
  logic             flush_next;
  logic [CNT_W-1:0] count_next;

  logic [31:0] jalr_sum;
  logic [31:0] branch_target;
  logic        in_boot;
  logic        in_run;
  logic        branch_accept;
  logic        trap_accept;
  logic        mret_accept;
  logic        redirect;

  // JALR clears bit 0 of its sum; every other branch form is PC-relative.
  assign jalr_sum      = rs1_in + imm_in;
  assign branch_target = (opcode_6_to_2_in == OPC_JALR) ? {jalr_sum[31:1], 1'b0}
                                                         : (pc_out + imm_in);
  assign pc_plus_4_out = pc_out + 32'd4;

  assign in_boot       = (state == ST_BOOT);
  assign in_run        = (state == ST_RUN);
  assign branch_accept = branch_taken_in & ~branch_target[1] & in_run;
  assign trap_accept   = trap_taken_in & ~in_boot;
  assign mret_accept   = mret_in & ~in_boot;
  assign redirect      = trap_accept | mret_accept | branch_accept;

  always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state              <= ST_BOOT;
      pc_out             <= BOOT_ADDRESS;
      flush_out          <= 1'b1;
      flush_cnt          <= 3'd0;
      redirect_count_out <= '0;
    end else if (!stall_in) begin
      state              <= state_next;
      pc_out             <= iaddr_out;
      flush_out          <= flush_next;
      flush_cnt          <= flush_cnt_next;
      redirect_count_out <= count_next;
    end
  end

  always_comb begin
    state_next     = state;
    flush_next     = flush_out;
    flush_cnt_next = flush_cnt;
    unique case (state)
      ST_BOOT: begin
        state_next = ST_RUN;
        flush_next = 1'b0;
      end
      ST_RUN: begin
        if (redirect) begin
          state_next     = ST_FLUSH;
          flush_next     = 1'b1;
          flush_cnt_next = FLUSH_RELOAD;
        end else begin
          flush_next = 1'b0;
        end
      end
      ST_FLUSH: begin
        // Execute holds a bubble here, so only trap/mret can extend the flush.
        if (trap_accept || mret_accept) begin
          flush_next     = 1'b1;
          flush_cnt_next = FLUSH_RELOAD;
        end else if (flush_cnt == 3'd0) begin
          state_next = ST_RUN;
          flush_next = 1'b0;
        end else begin
          flush_cnt_next = flush_cnt - 3'd1;
        end
      end
      default: begin
        state_next = ST_BOOT;
        flush_next = 1'b1;
      end
    endcase

    count_next = redirect_count_out;
    if (redirect && (redirect_count_out != {CNT_W{1'b1}})) begin
      count_next = redirect_count_out + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    misaligned_instr_out = branch_taken_in & branch_target[1] & in_run;
    iaddr_out            = pc_plus_4_out;
    if (in_boot) begin
      iaddr_out = BOOT_ADDRESS;
    end else if (trap_taken_in) begin
      iaddr_out = trap_address_in;
    end else if (mret_in) begin
      iaddr_out = epc_in;
    end else if (branch_accept) begin
      iaddr_out = branch_target;
    end
  end

endmodule

// File: tb/tb_msrv32_pc_redirect_ctrl.sv
// Directed self-checking bench for msrv32_pc_redirect_ctrl.
// A second instance with a narrow counter exercises saturation in few cycles.
module tb_msrv32_pc_redirect_ctrl;

  logic        clk;
  logic        rst;
  logic        branch_taken;
  logic [4:0]  opcode;
  logic [31:0] rs1;
  logic [31:0] imm;
  logic        trap_taken;
  logic [31:0] trap_address;
  logic        mret;
  logic [31:0] epc;
  logic        stall;
  logic [31:0] pc;
  logic [31:0] iaddr;
  logic [31:0] pc_plus_4;
  logic        misaligned;
  logic        flush;
  logic [15:0] count;

  logic [31:0] s_pc;
  logic [31:0] s_iaddr;
  logic [31:0] s_pc_plus_4;
  logic        s_misaligned;
  logic        s_flush;
  logic [3:0]  s_count;

  int checks = 0;
  int errors = 0;

  msrv32_pc_redirect_ctrl dut (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst),
    .branch_taken_in      (branch_taken),
    .opcode_6_to_2_in     (opcode),
    .rs1_in               (rs1),
    .imm_in               (imm),
    .trap_taken_in        (trap_taken),
    .trap_address_in      (trap_address),
    .mret_in              (mret),
    .epc_in               (epc),
    .stall_in             (stall),
    .pc_out               (pc),
    .iaddr_out            (iaddr),
    .pc_plus_4_out        (pc_plus_4),
    .misaligned_instr_out (misaligned),
    .flush_out            (flush),
    .redirect_count_out   (count)
  );

  msrv32_pc_redirect_ctrl #(.CNT_W(4)) dut_small (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst),
    .branch_taken_in      (branch_taken),
    .opcode_6_to_2_in     (opcode),
    .rs1_in               (rs1),
    .imm_in               (imm),
    .trap_taken_in        (trap_taken),
    .trap_address_in      (trap_address),
    .mret_in              (mret),
    .epc_in               (epc),
    .stall_in             (stall),
    .pc_out               (s_pc),
    .iaddr_out            (s_iaddr),
    .pc_plus_4_out        (s_pc_plus_4),
    .misaligned_instr_out (s_misaligned),
    .flush_out            (s_flush),
    .redirect_count_out   (s_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    branch_taken = 1'b0; opcode = 5'b0; rs1 = '0; imm = '0;
    trap_taken = 1'b0; trap_address = '0; mret = 1'b0; epc = '0; stall = 1'b0;
    #2;
    checks++; if (pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc got %h want %h", pc, 32'h0); end
    checks++; if (flush !== 1'b1) begin errors++; $display("[TB] FAIL reset_flush got %b want 1", flush); end
    checks++; if (count !== 16'h0) begin errors++; $display("[TB] FAIL reset_count got %h want 0", count); end
    rst = 1'b0;
    #1;
    checks++; if (iaddr !== 32'h0) begin errors++; $display("[TB] FAIL boot_iaddr got %h want 0", iaddr); end
    tick();
    checks++; if (pc !== 32'h0) begin errors++; $display("[TB] FAIL boot_pc got %h want 0", pc); end
    checks++; if (flush !== 1'b0) begin errors++; $display("[TB] FAIL boot_flush got %b want 0", flush); end
    checks++; if (iaddr !== 32'h4) begin errors++; $display("[TB] FAIL run_iaddr got %h want 4", iaddr); end
    checks++; if (pc_plus_4 !== 32'h4) begin errors++; $display("[TB] FAIL pc_plus_4 got %h want 4", pc_plus_4); end
  endtask

  task automatic test_sequential();
    for (int i = 1; i <= 64; i++) begin
      tick();
      checks++;
      if (pc !== 32'(i * 4)) begin
        errors++;
        $display("[TB] FAIL seq_pc step %0d got %h want %h", i, pc, 32'(i * 4));
      end
    end
  endtask

  task automatic test_branch();
    opcode = 5'b11000; branch_taken = 1'b1; imm = 32'h40;
    #1;
    checks++; if (iaddr !== 32'h140) begin errors++; $display("[TB] FAIL branch_iaddr got %h want 140", iaddr); end
    checks++; if (misaligned !== 1'b0) begin errors++; $display("[TB] FAIL branch_misaligned got %b want 0", misaligned); end
    tick();
    branch_taken = 1'b0;
    checks++; if (pc !== 32'h140) begin errors++; $display("[TB] FAIL branch_pc got %h want 140", pc); end
    checks++; if (flush !== 1'b1) begin errors++; $display("[TB] FAIL branch_flush got %b want 1", flush); end
    checks++; if (count !== 16'd1) begin errors++; $display("[TB] FAIL branch_count got %0d want 1", count); end
    tick();
    checks++; if (flush !== 1'b0) begin errors++; $display("[TB] FAIL branch_flush_end got %b want 0", flush); end
    checks++; if (pc !== 32'h144) begin errors++; $display("[TB] FAIL branch_pc_after got %h want 144", pc); end
  endtask

  task automatic test_targets();
    // Wrap-around of the PC-relative add: 0x144 + 0xFFFFFF00 = 0x44.
    opcode = 5'b11000; branch_taken = 1'b1; imm = 32'hFFFF_FF00;
    #1;
    checks++; if (iaddr !== 32'h44) begin errors++; $display("[TB] FAIL wrap_iaddr got %h want 44", iaddr); end
    opcode = 5'b11001; rs1 = 32'hFFFF_FFFF; imm = 32'h1;
    #1;
    checks++; if (iaddr !== 32'h0) begin errors++; $display("[TB] FAIL jalr_wrap_iaddr got %h want 0", iaddr); end
    rs1 = 32'h203; imm = 32'h0;
    #1;
    checks++; if (misaligned !== 1'b1) begin errors++; $display("[TB] FAIL misaligned got %b want 1", misaligned); end
    checks++; if (iaddr !== 32'h148) begin errors++; $display("[TB] FAIL misaligned_iaddr got %h want 148", iaddr); end
    tick();
    branch_taken = 1'b0;
    checks++; if (pc !== 32'h148) begin errors++; $display("[TB] FAIL misaligned_pc got %h want 148", pc); end
    checks++; if (flush !== 1'b0) begin errors++; $display("[TB] FAIL misaligned_flush got %b want 0", flush); end
    checks++; if (count !== 16'd1) begin errors++; $display("[TB] FAIL misaligned_count got %0d want 1", count); end
  endtask

  task automatic test_trap_mret();
    opcode = 5'b11000; imm = 32'h40; branch_taken = 1'b1;
    trap_taken = 1'b1; trap_address = 32'h80;
    #1;
    checks++; if (iaddr !== 32'h80) begin errors++; $display("[TB] FAIL trap_iaddr got %h want 80", iaddr); end
    tick();
    trap_taken = 1'b0; branch_taken = 1'b0;
    checks++; if (pc !== 32'h80) begin errors++; $display("[TB] FAIL trap_pc got %h want 80", pc); end
    checks++; if (count !== 16'd2) begin errors++; $display("[TB] FAIL trap_count got %0d want 2", count); end
    checks++; if (flush !== 1'b1) begin errors++; $display("[TB] FAIL trap_flush got %b want 1", flush); end
    mret = 1'b1; epc = 32'h144;
    #1;
    checks++; if (iaddr !== 32'h144) begin errors++; $display("[TB] FAIL mret_iaddr got %h want 144", iaddr); end
    tick();
    mret = 1'b0;
    checks++; if (pc !== 32'h144) begin errors++; $display("[TB] FAIL mret_pc got %h want 144", pc); end
    checks++; if (count !== 16'd3) begin errors++; $display("[TB] FAIL mret_count got %0d want 3", count); end
    checks++; if (flush !== 1'b1) begin errors++; $display("[TB] FAIL mret_flush got %b want 1", flush); end
    tick();
    checks++; if (flush !== 1'b0) begin errors++; $display("[TB] FAIL mret_flush_end got %b want 0", flush); end
    checks++; if (pc !== 32'h148) begin errors++; $display("[TB] FAIL mret_pc_after got %h want 148", pc); end
  endtask

  task automatic test_stall();
    opcode = 5'b11000; imm = 32'h10; branch_taken = 1'b1;
    tick();
    branch_taken = 1'b0;
    checks++; if (pc !== 32'h158) begin errors++; $display("[TB] FAIL stall_entry_pc got %h want 158", pc); end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (pc !== 32'h158) begin errors++; $display("[TB] FAIL stall_pc cycle %0d got %h want 158", i, pc); end
      checks++; if (flush !== 1'b1) begin errors++; $display("[TB] FAIL stall_flush cycle %0d got %b want 1", i, flush); end
      checks++; if (count !== 16'd4) begin errors++; $display("[TB] FAIL stall_count cycle %0d got %0d want 4", i, count); end
    end
    checks++; if (iaddr !== 32'h15C) begin errors++; $display("[TB] FAIL stall_iaddr got %h want 15c", iaddr); end
    stall = 1'b0;
    tick();
    checks++; if (flush !== 1'b0) begin errors++; $display("[TB] FAIL stall_flush_end got %b want 0", flush); end
    checks++; if (pc !== 32'h15C) begin errors++; $display("[TB] FAIL stall_pc_after got %h want 15c", pc); end
  endtask

  task automatic test_reset_mid_flush();
    trap_taken = 1'b1; trap_address = 32'h200;
    tick();
    trap_taken = 1'b0;
    checks++; if (count !== 16'd5) begin errors++; $display("[TB] FAIL pre_reset_count got %0d want 5", count); end
    checks++; if (flush !== 1'b1) begin errors++; $display("[TB] FAIL pre_reset_flush got %b want 1", flush); end
    rst = 1'b1;
    #1;
    checks++; if (flush !== 1'b1) begin errors++; $display("[TB] FAIL midreset_flush got %b want 1", flush); end
    checks++; if (pc !== 32'h0) begin errors++; $display("[TB] FAIL midreset_pc got %h want 0", pc); end
    checks++; if (count !== 16'd0) begin errors++; $display("[TB] FAIL midreset_count got %0d want 0", count); end
    checks++; if (iaddr !== 32'h0) begin errors++; $display("[TB] FAIL midreset_iaddr got %h want 0", iaddr); end
  endtask

  task automatic test_back_to_back();
    mret = 1'b1; epc = 32'h300;
    rst = 1'b0;
    tick();
    checks++; if (count !== 16'd0) begin errors++; $display("[TB] FAIL boot_ignores_mret got %0d want 0", count); end
    checks++; if (pc !== 32'h0) begin errors++; $display("[TB] FAIL boot_pc_mret got %h want 0", pc); end
    for (int i = 0; i < 20; i++) tick();
    mret = 1'b0;
    checks++; if (count !== 16'd20) begin errors++; $display("[TB] FAIL b2b_count got %0d want 20", count); end
    checks++; if (s_count !== 4'hF) begin errors++; $display("[TB] FAIL saturate_count got %h want f", s_count); end
    checks++; if (pc !== 32'h300) begin errors++; $display("[TB] FAIL b2b_pc got %h want 300", pc); end
    checks++; if (flush !== 1'b1) begin errors++; $display("[TB] FAIL b2b_flush got %b want 1", flush); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_targets();
    test_trap_mret();
    test_stall();
    test_reset_mid_flush();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
